lock_chamber_controller: RTL and testbench

Sequencer for the two-gate canal lock. It consumes the qualified boat-arrival and boat-departure requests plus the chamber water-level sensors, and drives the fill/drain valves and both gates. Each boat transit runs as a fixed sequence: equalize, open the entry gate, dwell, close, equalize to the far side, open the exit gate, dwell, close. Simultaneous requests from the two sides are arbitrated round-robin, and a stuck equalization latches a fault.

---
 rtl/lock_chamber_controller.sv | 149 ++++++++++++++
 tb/tb_lock_chamber_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_chamber_controller.sv
// Two-gate canal lock sequencer: arbitrates boat requests, equalizes the chamber
// through the fill/drain valves, and cycles the entry and exit gates for one transit.
module lock_chamber_controller #(
  parameter int DWELL_CYCLES  = 16,
  parameter int MAX_EQ_CYCLES = 255,
  parameter int CNT_W         = 8
) (
  input  logic       timer,
  input  logic       rst,
  input  logic       arriveSignal,
  input  logic       leaveSignal,
  input  logic       pressureUp,
  input  logic       pressureDown,
  output logic       outPort,
  output logic       inPort,
  output logic       fillValve,
  output logic       drainValve,
  output logic       arriveAck,
  output logic       leaveAck,
  output logic       busy,
  output logic       inbound,
  output logic       fault,
  output logic [2:0] dbg_state_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] EQ_A    = 3'd1;
  localparam logic [2:0] OPEN_A  = 3'd2;
  localparam logic [2:0] CLOSE_A = 3'd3;
  localparam logic [2:0] EQ_B    = 3'd4;
  localparam logic [2:0] OPEN_B  = 3'd5;
  localparam logic [2:0] CLOSE_B = 3'd6;
  localparam logic [2:0] FAULT   = 3'd7;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] EQ_LIMIT   = CNT_W'(MAX_EQ_CYCLES);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             inbound_q, inbound_d;
  logic             prefer_outer_q, prefer_outer_d;
  logic             fill_q, fill_d;
  logic             drain_q, drain_d;
  logic             arrive_ack_q, leave_ack_q;
  logic             take_outer, take_inner;
  logic             sensor_a, sensor_b;
  logic             eq_timeout, dwell_done;

  // Handshake: arriveSignal/leaveSignal are level requests that stay up until
  // served; a request is consumed only in IDLE, and the matching ack is a
  // one-cycle registered pulse that coincides with the first EQ_A cycle.

  always_comb begin
    cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    eq_timeout = (cnt_inc >= EQ_LIMIT);
    dwell_done = (cnt_q == DWELL_LAST);
    sensor_a   = inbound_q ? pressureUp : pressureDown;
    sensor_b   = inbound_q ? pressureDown : pressureUp;
  end

  always_comb begin
    state_d        = state_q;
    inbound_d      = inbound_q;
    prefer_outer_d = prefer_outer_q;
    take_outer     = 1'b0;
    take_inner     = 1'b0;
    case (state_q)
      IDLE: begin
        if (arriveSignal && (!leaveSignal || prefer_outer_q)) begin
          take_outer = 1'b1;
        end else if (leaveSignal) begin
          take_inner = 1'b1;
        end
        if (take_outer || take_inner) begin
          state_d        = EQ_A;
          inbound_d      = take_outer;
          prefer_outer_d = take_inner;
        end
      end
      EQ_A: begin
        if (sensor_a) begin
          state_d = OPEN_A;
        end else if (eq_timeout) begin
          state_d = FAULT;
        end
      end
      OPEN_A:  if (dwell_done) state_d = CLOSE_A;
      CLOSE_A: state_d = EQ_B;
      EQ_B: begin
        if (sensor_b) begin
          state_d = OPEN_B;
        end else if (eq_timeout) begin
          state_d = FAULT;
        end
      end
      OPEN_B:  if (dwell_done) state_d = CLOSE_B;
      CLOSE_B: state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // Valves look at the sensor on the same edge that enters/holds EQ, so an
  // already-equalized chamber never sees its valve pulse.
  always_comb begin
    fill_d  = ((state_d == EQ_A) &&  inbound_d && !pressureUp) ||
              ((state_d == EQ_B) && !inbound_d && !pressureUp);
    drain_d = ((state_d == EQ_A) && !inbound_d && !pressureDown) ||
              ((state_d == EQ_B) &&  inbound_d && !pressureDown);
    cnt_d   = (state_d != state_q) ? '0 : cnt_inc;
  end

  always_ff @(posedge timer) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      inbound_q      <= 1'b0;
      prefer_outer_q <= 1'b1;
      fill_q         <= 1'b0;
      drain_q        <= 1'b0;
      arrive_ack_q   <= 1'b0;
      leave_ack_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      inbound_q      <= inbound_d;
      prefer_outer_q <= prefer_outer_d;
      fill_q         <= fill_d;
      drain_q        <= drain_d;
      arrive_ack_q   <= take_outer;
      leave_ack_q    <= take_inner;
    end
  end

  always_comb begin
    outPort     = ((state_q == OPEN_A) &&  inbound_q) || ((state_q == OPEN_B) && !inbound_q);
    inPort      = ((state_q == OPEN_A) && !inbound_q) || ((state_q == OPEN_B) &&  inbound_q);
    fillValve   = fill_q;
    drainValve  = drain_q;
    arriveAck   = arrive_ack_q;
    leaveAck    = leave_ack_q;
    busy        = (state_q != IDLE) && (state_q != FAULT);
    inbound     = inbound_q;
    fault       = (state_q == FAULT);
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_lock_chamber_controller.sv
// Bench for lock_chamber_controller: each transit's expected per-cycle output trace
// is built from segment lengths (equalize, dwell, gap) and compared cycle by cycle.
module tb_lock_chamber_controller;
  localparam int DWELL = 16;
  localparam int MAXEQ = 255;

  logic timer = 1'b0;
  logic rst = 1'b0;
  logic arriveSignal = 1'b0, leaveSignal = 1'b0;
  logic pressureUp = 1'b0, pressureDown = 1'b0;
  logic outPort, inPort, fillValve, drainValve, arriveAck, leaveAck, busy, inbound, fault;
  logic [2:0] dbg_state;

  int total = 0;
  int bad = 0;
  int mon_bad = 0;
  bit last_outer = 1'b0;
  logic [8:0] exp_q[$];

  lock_chamber_controller #(.DWELL_CYCLES(DWELL), .MAX_EQ_CYCLES(MAXEQ), .CNT_W(8)) dut (
    .timer(timer), .rst(rst),
    .arriveSignal(arriveSignal), .leaveSignal(leaveSignal),
    .pressureUp(pressureUp), .pressureDown(pressureDown),
    .outPort(outPort), .inPort(inPort), .fillValve(fillValve), .drainValve(drainValve),
    .arriveAck(arriveAck), .leaveAck(leaveAck), .busy(busy), .inbound(inbound),
    .fault(fault), .dbg_state_o(dbg_state)
  );

  always #5 timer = ~timer;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge timer) begin
    if (rst && ((outPort && inPort) || (fillValve && drainValve) ||
                ((outPort || inPort) && (fillValve || drainValve)))) begin
      mon_bad++;
    end
  end

  function automatic logic [8:0] outs();
    return {outPort, inPort, fillValve, drainValve, arriveAck, leaveAck, busy, inbound, fault};
  endfunction

  task automatic step();
    @(posedge timer);
    #1;
  endtask

  task automatic set_sensor(input bit outer_side, input bit v);
    if (outer_side) pressureUp = v;
    else pressureDown = v;
  endtask

  // d_a/d_b: valve cycles before the target sensor rises; 0 = already equalized
  task automatic run_transit(input bit req_o, input bit req_i, input int d_a, input int d_b,
                             input bit hold, input string tag);
    bit side, ga, gb, va, vb;
    int a, b, eb, ob, cb;
    logic [8:0] e, got;
    side = (req_o && req_i) ? !last_outer : req_o;
    last_outer = side;
    a  = (d_a == 0) ? 1 : d_a;
    eb = a + DWELL + 1;
    b  = (d_b == 0) ? 1 : d_b;
    ob = eb + b;
    cb = ob + DWELL;
    exp_q.delete();
    for (int i = 0; i <= cb + 1; i++) begin
      va = (i < d_a);
      ga = (i >= a) && (i < a + DWELL);
      vb = (i >= eb) && (i < eb + d_b);
      gb = (i >= ob) && (i < cb);
      if (side) e = {ga, gb, va, vb, i == 0, 1'b0, i <= cb, 1'b1, 1'b0};
      else      e = {gb, ga, vb, va, 1'b0, i == 0, i <= cb, 1'b0, 1'b0};
      exp_q.push_back(e);
    end
    arriveSignal = req_o;
    leaveSignal  = req_i;
    set_sensor(side, d_a == 0);
    set_sensor(!side, d_b == 0);
    for (int i = 0; i <= cb + 1; i++) begin
      step();
      got = outs();
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s cyc %0d: got %b need %b (out,in,fill,drain,aack,lack,busy,inb,fault)",
                 tag, i, got, e);
      end
      if (i == 0 && !hold) begin
        arriveSignal = 1'b0;
        leaveSignal  = 1'b0;
      end
      if (d_a > 0 && i == d_a - 1) set_sensor(side, 1'b1);
      if (i == a + DWELL / 2) set_sensor(side, 1'b0);
      if (d_b > 0 && i == eb + d_b - 1) set_sensor(!side, 1'b1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    arriveSignal = 1'b0;
    leaveSignal = 1'b0;
    step();
    rst = 1'b1;
    last_outer = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    total++;
    if (outs() !== 9'b0) begin
      bad++;
      $display("FAIL reset: got %b need %b", outs(), 9'b0);
    end
    rst = 1'b1;
    last_outer = 1'b0;
  endtask

  task automatic test_reset_mid_transit();
    bit seen;
    pressureUp = 1'b1;
    pressureDown = 1'b0;
    arriveSignal = 1'b1;
    step();
    arriveSignal = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      step();
      seen = outPort;
    end
    total++;
    if (seen !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_open: outPort got %b need 1", seen);
    end
    rst = 1'b0;
    step();
    total++;
    if (outs() !== 9'b0) begin
      bad++;
      $display("FAIL mid_reset_outs: got %b need %b", outs(), 9'b0);
    end
    rst = 1'b1;
    arriveSignal = 1'b1;
    leaveSignal = 1'b1;
    step();
    total++;
    if ({arriveAck, leaveAck, busy, inbound} !== 4'b1011) begin
      bad++;
      $display("FAIL mid_reset_ack: got %b need 1011", {arriveAck, leaveAck, busy, inbound});
    end
    do_reset();
  endtask

  task automatic test_inbound();
    pressureDown = 1'b0;
    run_transit(1'b1, 1'b0, 5, 7, 1'b0, "inbound");
  endtask

  task automatic test_round_robin();
    do_reset();
    run_transit(1'b1, 1'b1, 2, 1, 1'b1, "rr_first");
    run_transit(1'b1, 1'b1, 3, 4, 1'b1, "rr_second");
    run_transit(1'b1, 1'b1, 1, 2, 1'b0, "rr_third");
  endtask

  task automatic test_already_equalized();
    run_transit(1'b0, 1'b1, 0, 3, 1'b0, "equalized");
  endtask

  task automatic test_min_transit();
    run_transit(1'b1, 1'b0, 0, 0, 1'b0, "min_transit");
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 10; n++) begin
      r = $urandom_range(1, 3);
      run_transit(r[0], r[1], $urandom_range(0, 6), $urandom_range(0, 6), 1'b0, "random");
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    pressureUp = 1'b0;
    pressureDown = 1'b0;
    arriveSignal = 1'b1;
    step();
    arriveSignal = 1'b0;
    n = 0;
    for (int k = 0; k < 300 && !fault; k++) begin
      if (fillValve) n++;
      step();
    end
    total++;
    if (n !== MAXEQ) begin
      bad++;
      $display("FAIL timeout_fill_len: got %0d need %0d", n, MAXEQ);
    end
    total++;
    if (outs() !== 9'b000000011) begin
      bad++;
      $display("FAIL timeout_fault: got %b need %b", outs(), 9'b000000011);
    end
    for (int k = 0; k < 30; k++) begin
      arriveSignal = 1'($urandom_range(0, 1));
      leaveSignal = 1'($urandom_range(0, 1));
      pressureUp = 1'($urandom_range(0, 1));
      pressureDown = 1'($urandom_range(0, 1));
      step();
      total++;
      if (outs() !== 9'b000000011) begin
        bad++;
        $display("FAIL fault_sticky cyc %0d: got %b need %b", k, outs(), 9'b000000011);
      end
    end
    rst = 1'b0;
    step();
    total++;
    if (outs() !== 9'b0) begin
      bad++;
      $display("FAIL fault_reset: got %b need %b", outs(), 9'b0);
    end
    do_reset();
  endtask

  task automatic test_invariants();
    total++;
    if (mon_bad !== 0) begin
      bad++;
      $display("FAIL invariants: got %0d violating cycles need 0", mon_bad);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_transit();
    test_inbound();
    test_round_robin();
    test_already_equalized();
    test_min_transit();
    test_random();
    test_timeout();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
